watch_ctrl: RTL
===============

Name: watch_ctrl

Overview:
Front-end control stage that sits directly upstream of the stopwatch counter. It conditions two raw push-buttons (start/stop and clear) with synchronisation and debounce, and runs the run/pause/idle state machine. It generates the per-second count enable and the clear pulse that drive the counter's start_stop and clear inputs. The counter advances once per clock when start_stop is high, so this block emits start_stop as a single-cycle pulse once every TICK_DIV clocks while running.

Parameters:
TICK_DIV, 50000000, clocks per counted second; legal range >= 1.
DB_CYCLES, 1000000, consecutive stable clocks required to accept a button level change; legal range >= 1.

Ports:
clk  input  1  system clock; single clock domain.
rst_n  input  1  asynchronous active-low reset.
btn_start  input  1  raw start/stop button, active-high, asynchronous to clk.
btn_clear  input  1  raw clear button, active-high, asynchronous to clk.
start_stop  output  1  count-enable pulse to the counter, high for one cycle per elapsed second while running.
clear  output  1  one-cycle clear pulse to the counter.
running  output  1  high while in RUN; drives the status LED.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; state IDLE; sync flops 0; debounced levels 0; debounce counters and prescaler 0. All outputs are registered.
- Synchroniser: each button passes through a 2-flop chain, giving s2.
- Debounce (per button):
  - Counter width clog2(DB_CYCLES+1).
  - If s2 equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments. When the counter has counted DB_CYCLES consecutive differing cycles, the debounced level takes s2 and the counter clears.
  - Any glitch shorter than DB_CYCLES clocks is ignored.
- Press detect: registered one-cycle press pulse on each debounced 0->1 transition only. Release generates nothing. Holding a button produces exactly one press.
- Latency: raw rising edge first sampled at clock edge 0 -> state and running update at edge DB_CYCLES+4.
- FSM states: IDLE (stopped, counter zero), RUN, PAUSE (stopped, value held).
  - IDLE: start press -> RUN. Clear press -> IDLE and pulse clear.
  - RUN: start press -> PAUSE. Clear press is ignored.
  - PAUSE: start press -> RUN. Clear press -> IDLE and pulse clear.
- Simultaneous start and clear presses in the same cycle:
  - In IDLE or PAUSE, clear wins: go to IDLE, pulse clear, drop the start press.
  - In RUN, start wins: go to PAUSE, drop the clear press.
- running = (state == RUN), registered together with the state.
- Prescaler:
  - Width clog2(TICK_DIV); counts 0..TICK_DIV-1 only while the state is RUN.
  - Holds its value in PAUSE, so partial seconds are preserved across pause/resume.
  - Forced to 0 on the edge where clear pulses.
- start_stop: registered. Goes high for one cycle on the edge after a RUN cycle in which prescaler == TICK_DIV-1; the prescaler wraps to 0 on that same edge.
  - The tick decision uses the current (pre-transition) state. A tick falling on the same cycle as a pause press is still issued.
- TICK_DIV = 1: start_stop stays high continuously while in RUN.
- First start_stop after IDLE->RUN arrives TICK_DIV clocks after running rises.
- clear and start_stop are never high in the same cycle, because clear is only issued from IDLE/PAUSE.
- Reset asserted mid-operation: return immediately to the reset values above. Any button still held at release of reset is accepted as a press once debounced.

Test Plan:
1. DB_CYCLES=4, TICK_DIV=5: hold btn_start high for 20 clocks -> running rises at edge 8. start_stop pulses at edges 13 and 18, then every 5 clocks; exactly one state change despite the long hold.
2. btn_start glitch high for 3 clocks (DB_CYCLES=4) -> no press; running stays 0; no start_stop.
3. Run, then press start again 2 clocks after a tick -> PAUSE, start_stop stops. Press start again -> next start_stop arrives 3 clocks after running re-rises (partial second held).
4. In PAUSE, press btn_clear -> clear high for exactly 1 cycle, state IDLE, prescaler 0. In RUN, press btn_clear -> clear stays 0 and running stays 1.
5. Start and clear debounced-pressed in the same cycle: from PAUSE -> IDLE with a clear pulse and running 0; from RUN -> PAUSE with no clear pulse.
6. Assert rst_n low mid-RUN, asynchronously between clock edges -> all outputs 0 immediately. Release with buttons low -> state stays IDLE, no pulses.

Source files
------------

// File: rtl/watch_ctrl.sv
// Stopwatch front end: synchronises and debounces the start/clear buttons,
// runs the IDLE/RUN/PAUSE state machine and produces the counter enable and clear pulses.

module watch_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start,
  input  logic btn_clear,
  output logic start_stop,
  output logic clear,
  output logic running
);

  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Bit 0 carries the start button, bit 1 the clear button, through every stage.
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         level;
  logic [1:0]         level_q;
  logic [1:0]         press;
  logic [1:0][DW-1:0] db_cnt;

  state_t        state;
  state_t        state_next;
  logic          clear_next;
  logic          tick;
  logic [PW-1:0] pre_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_clear, btn_start};
      sync2 <= sync1;
    end
  end

  // A level change is accepted only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level  <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      press   <= '0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

  assign tick = (state == RUN) && (pre_cnt == PRE_LAST);

  // Clear has priority outside RUN; inside RUN only start is honoured.
  always_comb begin
    state_next = state;
    clear_next = 1'b0;
    case (state)
      IDLE: begin
        if (press[1]) begin
          clear_next = 1'b1;
        end else if (press[0]) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (press[0]) begin
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (press[1]) begin
          state_next = IDLE;
          clear_next = 1'b1;
        end else if (press[0]) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      running    <= 1'b0;
      clear      <= 1'b0;
      start_stop <= 1'b0;
    end else begin
      state      <= state_next;
      running    <= (state_next == RUN);
      clear      <= clear_next;
      start_stop <= tick;
    end
  end

  // The prescaler only holds in PAUSE, so a resumed run keeps its partial second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (clear_next) begin
      pre_cnt <= '0;
    end else if (state == RUN) begin
      if (tick) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

endmodule
